// File: rtl/text_line_scheduler_if.sv
// text_line_scheduler_if
// Write port between game-state logic and text_line_scheduler.
// Game logic queues letter codes through this port. A write is accepted on a
// clock where wr_valid_in and wr_ready_out are both high.
//
// Signals:
//   wr_valid_in   write request
//   wr_ready_out  scheduler can accept a write
//   wr_addr_in    character slot index
//   wr_letter_in  letter code, 0 = blank
//   wr_last_in    final write of a batch; requests a commit at the next frame
//   scale_in      scale exponent, sampled with the last write
//
// Modports: master = game logic side, slave = scheduler side.
interface text_line_scheduler_if #(
   parameter int ADDR_W = 4
);
   logic              wr_valid_in;
   logic              wr_ready_out;
   logic [ADDR_W-1:0] wr_addr_in;
   logic [4:0]        wr_letter_in;
   logic              wr_last_in;
   logic [3:0]        scale_in;

   modport master (
      output wr_valid_in, wr_addr_in, wr_letter_in, wr_last_in, scale_in,
      input  wr_ready_out
   );

   modport slave (
      input  wr_valid_in, wr_addr_in, wr_letter_in, wr_last_in, scale_in,
      output wr_ready_out
   );
endinterface

// File: rtl/text_line_scheduler.sv
// text_line_scheduler
// Sequences the shared glyph renderer across a one-line text string.
// Game logic fills a shadow buffer through the write interface. The shadow
// buffer is copied into the active buffer only on a frame-start pulse, so a
// frame never shows a half-updated string. For every pixel the block reports
// which letter, glyph column and glyph row is being drawn. Its outputs are
// aligned with hcount/vcount delayed by two clocks.
//
// Ports:
//   clk_pixel_in     pixel clock
//   rst_in           synchronous active-high reset
//   hcount_in        horizontal pixel count (+1 per clock within a line)
//   vcount_in        vertical line count
//   new_frame_in     one-cycle pulse at frame start
//   wr               write interface (slave modport)
//   letter_out       letter code of the current pixel
//   glyph_x_out      glyph column
//   glyph_y_out      glyph row
//   glyph_valid_out  pixel lies inside a non-blank, visible glyph
//   hcount_out       hcount_in delayed 2 clocks
//   vcount_out       vcount_in delayed 2 clocks
//   busy_out         a committed batch is waiting for the next frame start
//
// Optional feature, enabled by defining the macro TYPEWRITER_EN:
//   Characters are revealed one at a time, one every REVEAL_FRAMES frames,
//   starting from the commit. Without the macro, all slots show at once.
module text_line_scheduler #(
   parameter int X_POS         = 128,
   parameter int Y_POS         = 128,
   parameter int NUM_CHARS     = 16,
   parameter int GLYPH_W       = 12,
   parameter int GLYPH_H       = 12,
   parameter int SPACING       = 2,
   parameter int REVEAL_FRAMES = 8
) (
   input  logic                         clk_pixel_in,
   input  logic                         rst_in,
   input  logic [10:0]                  hcount_in,
   input  logic [9:0]                   vcount_in,
   input  logic                         new_frame_in,
   text_line_scheduler_if.slave         wr,
   output logic [4:0]                   letter_out,
   output logic [3:0]                   glyph_x_out,
   output logic [3:0]                   glyph_y_out,
   output logic                         glyph_valid_out,
   output logic [10:0]                  hcount_out,
   output logic [9:0]                   vcount_out,
   output logic                         busy_out
);
   localparam int ADDR_W = $clog2(NUM_CHARS);
   localparam int PITCH  = GLYPH_W + SPACING;
   localparam int COL_W  = $clog2(PITCH);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(PITCH - 1);
   localparam logic [COL_W-1:0]  COL_GLYPH = COL_W'(GLYPH_W);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_CHARS - 1);

   // Reject configurations that the counter widths cannot represent.
   if ((NUM_CHARS < 2) || (NUM_CHARS > 32) || ((1 << ADDR_W) != NUM_CHARS))
      $error("NUM_CHARS must be a power of two in 2..32");
   if (REVEAL_FRAMES < 1)
      $error("REVEAL_FRAMES must be at least 1");

   typedef enum logic {
      FILL    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  shadow_q [NUM_CHARS];
   logic [4:0]  active_q [NUM_CHARS];
   logic [1:0]  pend_scale_q;
   logic [1:0]  scale_q;
   logic [1:0]  scale_clamped;
   logic        accept;
   logic        commit;

   // Only scales 0..3 are supported, so larger exponents saturate at 3.
   assign scale_clamped = (wr.scale_in > 4'd3) ? 2'd3 : wr.scale_in[1:0];

   // Handshake FSM. A batch becomes pending on its last write. It is committed
   // only on a frame-start pulse that arrives while the batch is pending. A
   // pulse in the same cycle as the last write therefore does not commit it.
   always_comb begin
      state_d         = state_q;
      wr.wr_ready_out = 1'b0;
      busy_out        = 1'b0;
      accept          = 1'b0;
      commit          = 1'b0;
      unique case (state_q)
         FILL: begin
            wr.wr_ready_out = !rst_in;
            accept          = wr.wr_valid_in && !rst_in;
            if (accept && wr.wr_last_in)
               state_d = PENDING;
         end
         PENDING: begin
            busy_out = !rst_in;
            if (new_frame_in) begin
               commit  = 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State, shadow/active buffers and scale. The commit copies every slot in
   // one clock. It happens only at frame start, so a line never sees a mix of
   // old and new text.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         state_q      <= FILL;
         pend_scale_q <= 2'd0;
         scale_q      <= 2'd0;
         for (int i = 0; i < NUM_CHARS; i++) begin
            shadow_q[i] <= 5'd0;
            active_q[i] <= 5'd0;
         end
      end else begin
         state_q <= state_d;
         if (accept) begin
            shadow_q[wr.wr_addr_in] <= wr.wr_letter_in;
            if (wr.wr_last_in)
               pend_scale_q <= scale_clamped;
         end
         if (commit) begin
            for (int i = 0; i < NUM_CHARS; i++)
               active_q[i] <= shadow_q[i];
            scale_q <= pend_scale_q;
         end
      end
   end

   logic visible;

`ifdef TYPEWRITER_EN
   localparam int FRAME_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(REVEAL_FRAMES - 1);
   localparam logic [ADDR_W:0]    REVEAL_MAX = (ADDR_W + 1)'(NUM_CHARS);

   logic [FRAME_W-1:0] frame_cnt_q;
   logic [ADDR_W:0]    reveal_q;

   // The reveal counter starts from zero at every commit. It then adds one
   // character every REVEAL_FRAMES frame pulses, up to the full string.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in || commit) begin
         frame_cnt_q <= '0;
         reveal_q    <= '0;
      end else if (new_frame_in) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_q <= '0;
            if (reveal_q != REVEAL_MAX)
               reveal_q <= reveal_q + 1'b1;
         end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end
`endif

   // Stage 1: horizontal position counters and the vertical row. There is no
   // divider. sub counts the scaled copies of one glyph pixel, col counts
   // columns within one glyph pitch, and idx counts character slots.
   logic [2:0]        sub_max;
   logic [2:0]        sub_q;
   logic [COL_W-1:0]  col_q;
   logic [ADDR_W-1:0] idx_q;
   logic              in_line_q;
   logic [9:0]        ry;
   logic [10:0]       row_lim;
   logic              row_ok_q;
   logic [3:0]        gy_q;
   logic [10:0]       hcount_d1_q;
   logic [9:0]        vcount_d1_q;

   always_comb begin
      sub_max = 3'd0;
      unique case (scale_q)
         2'd0: sub_max = 3'd0;
         2'd1: sub_max = 3'd1;
         2'd2: sub_max = 3'd3;
         2'd3: sub_max = 3'd7;
         default: sub_max = 3'd0;
      endcase
   end

   // The subtraction is unsigned, so lines above the string wrap to large
   // values and fail the row-limit compare.
   assign ry      = vcount_in - 10'(Y_POS);
   assign row_lim = 11'(GLYPH_H) << scale_q;

   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         sub_q       <= 3'd0;
         col_q       <= '0;
         idx_q       <= '0;
         in_line_q   <= 1'b0;
         row_ok_q    <= 1'b0;
         gy_q        <= 4'd0;
         hcount_d1_q <= 11'd0;
         vcount_d1_q <= 10'd0;
      end else begin
         hcount_d1_q <= hcount_in;
         vcount_d1_q <= vcount_in;
         row_ok_q    <= ({1'b0, ry} < row_lim);
         gy_q        <= 4'(ry >> scale_q);
         if (hcount_in == 11'(X_POS)) begin
            sub_q     <= 3'd0;
            col_q     <= '0;
            idx_q     <= '0;
            in_line_q <= 1'b1;
         end else if (hcount_in < 11'(X_POS)) begin
            in_line_q <= 1'b0;
         end else if (in_line_q) begin
            if (sub_q == sub_max) begin
               sub_q <= 3'd0;
               if (col_q == COL_LAST) begin
                  col_q <= '0;
                  if (idx_q == IDX_LAST)
                     in_line_q <= 1'b0;
                  else
                     idx_q <= idx_q + 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end else begin
               sub_q <= sub_q + 1'b1;
            end
         end
      end
   end

   // Stage 2: resolve the pixel and register every output. A pixel outside a
   // visible glyph forces letter and coordinates to zero.
   logic [4:0] cur_letter;
   logic       pix_valid;

`ifdef TYPEWRITER_EN
   assign visible = ({1'b0, idx_q} < reveal_q);
`else
   assign visible = 1'b1;
`endif

   assign cur_letter = active_q[idx_q];
   assign pix_valid  = in_line_q && row_ok_q && (col_q < COL_GLYPH) &&
                       (cur_letter != 5'd0) && visible;

   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         letter_out      <= 5'd0;
         glyph_x_out     <= 4'd0;
         glyph_y_out     <= 4'd0;
         glyph_valid_out <= 1'b0;
         hcount_out      <= 11'd0;
         vcount_out      <= 10'd0;
      end else begin
         hcount_out      <= hcount_d1_q;
         vcount_out      <= vcount_d1_q;
         glyph_valid_out <= pix_valid;
         letter_out      <= pix_valid ? cur_letter : 5'd0;
         glyph_x_out     <= pix_valid ? 4'(col_q) : 4'd0;
         glyph_y_out     <= pix_valid ? gy_q : 4'd0;
      end
   end
endmodule

// File: tb/tb_text_line_scheduler.sv
// tb_text_line_scheduler
// Self-checking bench for text_line_scheduler. It uses a table of scan
// vectors and hand-written sequences for the commit, reset and typewriter
// cases.
module tb_text_line_scheduler;
   localparam int NUM_CHARS = 16;
   localparam int ADDR_W    = 4;

   logic        clk_pixel_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        new_frame_in;
   logic [4:0]  letter_out;
   logic [3:0]  glyph_x_out;
   logic [3:0]  glyph_y_out;
   logic        glyph_valid_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        busy_out;

   int checks = 0;
   int passes = 0;

   text_line_scheduler_if #(.ADDR_W(ADDR_W)) wr_if ();

   text_line_scheduler #(
      .X_POS(128), .Y_POS(128), .NUM_CHARS(NUM_CHARS), .GLYPH_W(12),
      .GLYPH_H(12), .SPACING(2), .REVEAL_FRAMES(2)
   ) dut (
      .clk_pixel_in   (clk_pixel_in),
      .rst_in         (rst_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .new_frame_in   (new_frame_in),
      .wr             (wr_if),
      .letter_out     (letter_out),
      .glyph_x_out    (glyph_x_out),
      .glyph_y_out    (glyph_y_out),
      .glyph_valid_out(glyph_valid_out),
      .hcount_out     (hcount_out),
      .vcount_out     (vcount_out),
      .busy_out       (busy_out)
   );

   always #5 clk_pixel_in = ~clk_pixel_in;

   typedef struct {
      int         h;
      int         v;
      logic       valid;
      logic [4:0] letter;
      logic [3:0] gx;
      logic [3:0] gy;
   } vec_t;

   vec_t vt [0:24];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected)
         passes++;
      else
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk_pixel_in);
      #1;
   endtask

   task automatic doReset();
      rst_in = 1'b1;
      repeat (3) tick();
      rst_in = 1'b0;
   endtask

   task automatic newFrame();
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
   endtask

   // Run one scan line from hcount 0 up to h, then clock once more. After that
   // extra clock the outputs belong to pixel (h, v).
   task automatic applyStimulus(input int h, input int v);
      vcount_in = 10'(v);
      for (int x = 0; x <= h; x++) begin
         hcount_in = 11'(x);
         tick();
      end
      tick();
   endtask

   task automatic writeSlot(input int addr, input int letter, input bit last, input int scale);
      bit done = 1'b0;
      wr_if.wr_valid_in  = 1'b1;
      wr_if.wr_addr_in   = ADDR_W'(addr);
      wr_if.wr_letter_in = 5'(letter);
      wr_if.wr_last_in   = last;
      wr_if.scale_in     = 4'(scale);
      for (int k = 0; k < 8 && !done; k++) begin
         if (wr_if.wr_ready_out) done = 1'b1;
         tick();
      end
      wr_if.wr_valid_in = 1'b0;
      wr_if.wr_last_in  = 1'b0;
      checkOutput($sformatf("write_accept[%0d]", addr), int'(done), 1);
   endtask

   task automatic checkVector(input int i);
      applyStimulus(vt[i].h, vt[i].v);
      checkOutput($sformatf("vec%0d_valid", i),  int'(glyph_valid_out), int'(vt[i].valid));
      checkOutput($sformatf("vec%0d_letter", i), int'(letter_out),      int'(vt[i].letter));
      checkOutput($sformatf("vec%0d_gx", i),     int'(glyph_x_out),     int'(vt[i].gx));
      checkOutput($sformatf("vec%0d_gy", i),     int'(glyph_y_out),     int'(vt[i].gy));
      checkOutput($sformatf("vec%0d_hcount", i), int'(hcount_out),      vt[i].h);
      checkOutput($sformatf("vec%0d_vcount", i), int'(vcount_out),      vt[i].v);
   endtask

   task automatic runVectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         checkVector(i);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Scale 0, pitch 14: slot0=1, slot1=5, slot15=31
      vt[0]  = '{128, 130, 1'b1, 5'd1,  4'd0,  4'd2};
      vt[1]  = '{140, 130, 1'b0, 5'd0,  4'd0,  4'd0};
      vt[2]  = '{139, 128, 1'b1, 5'd1,  4'd11, 4'd0};
      vt[3]  = '{142, 139, 1'b1, 5'd5,  4'd0,  4'd11};
      vt[4]  = '{142, 140, 1'b0, 5'd0,  4'd0,  4'd0};
      vt[5]  = '{127, 130, 1'b0, 5'd0,  4'd0,  4'd0};
      vt[6]  = '{156, 130, 1'b0, 5'd0,  4'd0,  4'd0};
      vt[7]  = '{338, 130, 1'b1, 5'd31, 4'd0,  4'd2};
      vt[8]  = '{349, 130, 1'b1, 5'd31, 4'd11, 4'd2};
      vt[9]  = '{352, 130, 1'b0, 5'd0,  4'd0,  4'd0};
      vt[10] = '{128, 127, 1'b0, 5'd0,  4'd0,  4'd0};
      // Scale 1, pitch 28: slot0=2, slot1=1
      vt[11] = '{156, 133, 1'b1, 5'd1,  4'd0,  4'd2};
      vt[12] = '{128, 133, 1'b1, 5'd2,  4'd0,  4'd2};
      vt[13] = '{129, 128, 1'b1, 5'd2,  4'd0,  4'd0};
      vt[14] = '{130, 151, 1'b1, 5'd2,  4'd1,  4'd11};
      vt[15] = '{130, 152, 1'b0, 5'd0,  4'd0,  4'd0};
      vt[16] = '{152, 128, 1'b0, 5'd0,  4'd0,  4'd0};
      // Old text still shown while the new batch is pending
      vt[17] = '{128, 128, 1'b1, 5'd2,  4'd0,  4'd0};
      // Scale clamped to 3, pitch 112: slot0=3, slot1=1 kept in shadow
      vt[18] = '{128, 128, 1'b1, 5'd3,  4'd0,  4'd0};
      vt[19] = '{136, 128, 1'b1, 5'd3,  4'd1,  4'd0};
      vt[20] = '{128, 223, 1'b1, 5'd3,  4'd0,  4'd11};
      vt[21] = '{128, 224, 1'b0, 5'd0,  4'd0,  4'd0};
      vt[22] = '{240, 128, 1'b1, 5'd1,  4'd0,  4'd0};
      // After reset during PENDING: nothing visible
      vt[23] = '{128, 128, 1'b0, 5'd0,  4'd0,  4'd0};
      vt[24] = '{142, 128, 1'b0, 5'd0,  4'd0,  4'd0};

      rst_in             = 1'b1;
      hcount_in          = 11'd0;
      vcount_in          = 10'd0;
      new_frame_in       = 1'b0;
      wr_if.wr_valid_in  = 1'b0;
      wr_if.wr_addr_in   = '0;
      wr_if.wr_letter_in = 5'd0;
      wr_if.wr_last_in   = 1'b0;
      wr_if.scale_in     = 4'd0;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_valid",  int'(glyph_valid_out), 0);
      checkOutput("rst_letter", int'(letter_out), 0);
      checkOutput("rst_gx",     int'(glyph_x_out), 0);
      checkOutput("rst_gy",     int'(glyph_y_out), 0);
      checkOutput("rst_hcount", int'(hcount_out), 0);
      checkOutput("rst_vcount", int'(vcount_out), 0);
      checkOutput("rst_busy",   int'(busy_out), 0);
      checkOutput("rst_ready",  int'(wr_if.wr_ready_out), 0);
      rst_in = 1'b0;
      tick();
      checkOutput("post_rst_ready", int'(wr_if.wr_ready_out), 1);

      // Scale 0 text
      writeSlot(0, 1, 1'b0, 0);
      writeSlot(1, 5, 1'b0, 0);
      writeSlot(15, 31, 1'b1, 0);
      checkOutput("a_busy_pending", int'(busy_out), 1);
      newFrame();
      checkOutput("a_busy_done", int'(busy_out), 0);
      runVectors(0, 10);

      // Scale 1 text
      doReset();
      writeSlot(0, 2, 1'b0, 0);
      writeSlot(1, 1, 1'b1, 1);
      newFrame();
      runVectors(11, 16);

      // Last write in the same cycle as frame start: the commit waits
      wr_if.wr_valid_in  = 1'b1;
      wr_if.wr_addr_in   = ADDR_W'(0);
      wr_if.wr_letter_in = 5'd3;
      wr_if.wr_last_in   = 1'b1;
      wr_if.scale_in     = 4'd15;
      new_frame_in       = 1'b1;
      tick();
      wr_if.wr_valid_in = 1'b0;
      wr_if.wr_last_in  = 1'b0;
      new_frame_in      = 1'b0;
      checkOutput("c_busy_pending", int'(busy_out), 1);
      checkOutput("c_ready_pending", int'(wr_if.wr_ready_out), 0);
      // A write while pending must be ignored
      wr_if.wr_valid_in  = 1'b1;
      wr_if.wr_letter_in = 5'd9;
      tick();
      tick();
      wr_if.wr_valid_in = 1'b0;
      runVectors(17, 17);
      newFrame();
      checkOutput("c_busy_done", int'(busy_out), 0);
      runVectors(18, 22);

      // Reset while pending discards the batch
      writeSlot(0, 7, 1'b1, 0);
      checkOutput("d_busy_pending", int'(busy_out), 1);
      rst_in = 1'b1;
      tick();
      checkOutput("d_busy_in_reset", int'(busy_out), 0);
      rst_in = 1'b0;
      tick();
      checkOutput("d_busy_after", int'(busy_out), 0);
      checkOutput("d_ready_after", int'(wr_if.wr_ready_out), 1);
      newFrame();
      runVectors(23, 24);

`ifdef TYPEWRITER_EN
      // Two characters revealed after four frame pulses at two frames each
      doReset();
      writeSlot(0, 1, 1'b0, 0);
      writeSlot(1, 2, 1'b0, 0);
      writeSlot(2, 3, 1'b0, 0);
      writeSlot(3, 4, 1'b1, 0);
      newFrame();
      repeat (4) newFrame();
      for (int s = 0; s < 4; s++) begin
         applyStimulus(128 + 14 * s, 128);
         checkOutput($sformatf("tw_slot%0d_valid", s), int'(glyph_valid_out), (s < 2) ? 1 : 0);
         checkOutput($sformatf("tw_slot%0d_letter", s), int'(letter_out), (s < 2) ? s + 1 : 0);
      end
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
